// File: rtl/gate_sweep_checker.sv
// Sweeps all eight a/b/c combinations into the 3-input gate network, samples x after
// a programmable dwell, and reports the captured truth table, mismatch count and first failure.
module gate_sweep_checker #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       x,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [2:0] first_fail,
    output logic [7:0] truth
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // x = (a ^ b) & ~(b ^ c) & c is high only for {a,b,c} = 011.
    localparam logic [7:0] EXP_TABLE = 8'h08;
    localparam logic [7:0] LAST_CNT  = 8'(DWELL - 1);

    state_t     state;
    logic [7:0] dwell_cnt;
    logic [2:0] pat;
    logic       mismatch;

    // pat wraps 7 -> 0 on the final sample, so it doubles as the registered stimulus
    // and naturally returns {a,b,c} to 000 in DONE.
    assign {a, b, c} = pat;
    assign mismatch  = (x != EXP_TABLE[pat]);
    assign pass      = done && (err_cnt == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dwell_cnt  <= 8'd0;
            pat        <= 3'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_cnt    <= 4'd0;
            first_fail <= 3'd0;
            truth      <= 8'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        dwell_cnt  <= 8'd0;
                        pat        <= 3'd0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        err_cnt    <= 4'd0;
                        first_fail <= 3'd0;
                        truth      <= 8'd0;
                    end
                end
                RUN: begin
                    if (dwell_cnt == LAST_CNT) begin
                        truth[pat] <= x;
                        if (mismatch) begin
                            err_cnt <= err_cnt + 4'd1;
                            if (err_cnt == 4'd0) begin
                                first_fail <= pat;
                            end
                        end
                        dwell_cnt <= 8'd0;
                        pat       <= pat + 3'd1;
                        if (pat == 3'd7) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: two instances (DWELL=4 and DWELL=2) driven by a
// table-lookup gate model, checked against a reference built from the gate's truth table.
module tb_gate_sweep_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sel;       // 0 -> DWELL=4 instance, 1 -> DWELL=2 instance
    logic [7:0] tbl;       // x as a function of {a,b,c} for the network under test

    logic       x4, a4, b4, c4, busy4, done4, pass4;
    logic [3:0] err4;
    logic [2:0] ff4;
    logic [7:0] truth4;
    logic       x2, a2, b2, c2, busy2, done2, pass2;
    logic [3:0] err2;
    logic [2:0] ff2;
    logic [7:0] truth2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gate_sweep_checker #(.DWELL(4)) dut4 (
        .clk(clk), .rst(rst), .start(start && !sel), .x(x4),
        .a(a4), .b(b4), .c(c4), .busy(busy4), .done(done4), .pass(pass4),
        .err_cnt(err4), .first_fail(ff4), .truth(truth4)
    );

    gate_sweep_checker #(.DWELL(2)) dut2 (
        .clk(clk), .rst(rst), .start(start && sel), .x(x2),
        .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err2), .first_fail(ff2), .truth(truth2)
    );

    assign x4 = tbl[{a4, b4, c4}];
    assign x2 = tbl[{a2, b2, c2}];

    logic [2:0] o_abc;
    logic       o_busy, o_done, o_pass;
    logic [3:0] o_err;
    logic [2:0] o_ff;
    logic [7:0] o_truth;
    assign o_abc   = sel ? {a2, b2, c2} : {a4, b4, c4};
    assign o_busy  = sel ? busy2 : busy4;
    assign o_done  = sel ? done2 : done4;
    assign o_pass  = sel ? pass2 : pass4;
    assign o_err   = sel ? err2 : err4;
    assign o_ff    = sel ? ff2 : ff4;
    assign o_truth = sel ? truth2 : truth4;

    // Run one sweep on the selected instance and check timing and results.
    task automatic run_sweep(input logic [7:0] t, input bit poke_start, input string name);
        int         dw;
        int         n;
        int         step_bad;
        int         exp_err;
        logic [2:0] exp_ff;
        logic [7:0] diff;
        dw  = sel ? 2 : 4;
        tbl = t;
        diff    = t ^ 8'h08;
        exp_err = $countones(diff);
        exp_ff  = 3'd0;
        for (int k = 7; k >= 0; k--) if (diff[k]) exp_ff = 3'(k);

        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        tests++;
        if (o_busy !== 1'b1 || o_done !== 1'b0 || o_abc !== 3'd0 || o_truth !== 8'd0 ||
            o_err !== 4'd0 || o_ff !== 3'd0 || o_pass !== 1'b0) begin
            fails++;
            $display("FAIL %s_accept: busy=%b done=%b abc=%0d truth=%h err=%0d ff=%0d pass=%b, need busy=1 done=0 rest 0",
                     name, o_busy, o_done, o_abc, o_truth, o_err, o_ff, o_pass);
        end

        n = 0;
        step_bad = 0;
        while (o_done !== 1'b1 && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            start = poke_start && (n == 5);
            if (o_done !== 1'b1) begin
                if (o_abc !== 3'(n / dw) || o_busy !== 1'b1 || o_pass !== 1'b0) step_bad++;
            end
        end
        start = 1'b0;

        tests++;
        if (n != 8 * dw) begin
            fails++;
            $display("FAIL %s_latency: done after %0d cycles, need %0d", name, n, 8 * dw);
        end
        tests++;
        if (step_bad != 0) begin
            fails++;
            $display("FAIL %s_stepping: %0d cycles with wrong abc/busy/pass, need 0", name, step_bad);
        end
        tests++;
        if (o_busy !== 1'b0 || o_abc !== 3'd0) begin
            fails++;
            $display("FAIL %s_done_state: busy=%b abc=%0d, need busy=0 abc=0", name, o_busy, o_abc);
        end
        tests++;
        if (o_truth !== t || o_err !== 4'(exp_err) || o_ff !== exp_ff || o_pass !== (exp_err == 0)) begin
            fails++;
            $display("FAIL %s_results: truth=%h err=%0d ff=%0d pass=%b, need truth=%h err=%0d ff=%0d pass=%b",
                     name, o_truth, o_err, o_ff, o_pass, t, exp_err, exp_ff, (exp_err == 0));
        end
    endtask

    task automatic check_reset_values(input string name);
        tests++;
        if ({a4, b4, c4, busy4, done4, pass4} !== 6'd0 || err4 !== 4'd0 || ff4 !== 3'd0 || truth4 !== 8'd0 ||
            {a2, b2, c2, busy2, done2, pass2} !== 6'd0 || err2 !== 4'd0 || ff2 !== 3'd0 || truth2 !== 8'd0) begin
            fails++;
            $display("FAIL %s: abc4=%b%b%b busy4=%b done4=%b err4=%0d truth4=%h abc2=%b%b%b busy2=%b done2=%b, need all 0",
                     name, a4, b4, c4, busy4, done4, err4, truth4, a2, b2, c2, busy2, done2);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; sel = 1'b0; tbl = 8'h08;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset_with_start");
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check_reset_values("idle_after_reset");
    endtask

    task automatic test_fixed_tables();
        sel = 1'b0;
        run_sweep(8'h08, 1'b0, "good_gate");
        run_sweep(8'h00, 1'b0, "stuck0");
        run_sweep(8'hFF, 1'b0, "stuck1");
    endtask

    task automatic test_random_tables();
        for (int i = 0; i < 4; i++) begin
            sel = 1'($urandom_range(0, 1));
            run_sweep(8'($urandom), 1'b0, "random");
        end
    endtask

    task automatic test_dwell2();
        sel = 1'b1;
        run_sweep(8'h08, 1'b0, "dwell2_good");
        run_sweep(8'h5A, 1'b0, "dwell2_faulty");
        sel = 1'b0;
    endtask

    task automatic test_start_in_run();
        sel = 1'b0;
        run_sweep(8'h28, 1'b1, "start_in_run");
    endtask

    task automatic test_midsweep_reset();
        int n;
        sel = 1'b0;
        tbl = 8'($urandom);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while ({a4, b4, c4} !== 3'd5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if ({a4, b4, c4} !== 3'd5) begin
            fails++;
            $display("FAIL reach_pattern5: abc=%b%b%b, need 101", a4, b4, c4);
        end
        #2 rst = 1'b1;
        #1 check_reset_values("async_reset_midsweep");
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check_reset_values("no_done_after_reset");
        run_sweep(8'h08, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [7:0] t;
        int         n;
        sel = 1'b0;
        t = 8'($urandom);
        run_sweep(t, 1'b0, "b2b_first");
        run_sweep(t, 1'b0, "b2b_repeat");

        // start held high: exactly one done cycle before the next sweep begins
        tbl = 8'h08;
        @(negedge clk); start = 1'b1;
        n = 0;
        while (done4 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (done4 !== 1'b1) begin
            fails++;
            $display("FAIL held_start_done: done=%b after %0d cycles, need 1", done4, n);
        end
        @(negedge clk);
        tests++;
        if (done4 !== 1'b0 || busy4 !== 1'b1 || truth4 !== 8'd0) begin
            fails++;
            $display("FAIL held_start_restart: done=%b busy=%b truth=%h, need done=0 busy=1 truth=00",
                     done4, busy4, truth4);
        end
        start = 1'b0;
        n = 0;
        while (done4 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_fixed_tables();
        test_dwell2();
        test_start_in_run();
        test_midsweep_reset();
        test_back_to_back();
        test_random_tables();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
